frame_streamer: RTL and testbench

FRAME_STREAMER -- requirements
Module: frame_streamer

---
 rtl/frame_streamer_if.sv | 31 +++
 rtl/frame_streamer.sv | 162 ++++++++++++++++
 tb/tb_frame_streamer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_streamer_if.sv
// Frame-streamer bus bundle.
// Groups the frame-buffer read port, the pixel stream towards the DUT,
// the DUT result input and the result write-back port.
//   master : streamer side (drives reads, pixel stream, write-back)
//   slave  : environment side (frame buffer and DUT under test)
interface frame_streamer_if #(
  parameter int PIXEL_SIZE = 24,
  parameter int ADDR_W     = 20
);
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [PIXEL_SIZE-1:0] rd_data;
  logic [PIXEL_SIZE-1:0] data;
  logic                  valid;
  logic                  hsync;
  logic                  vsync;
  logic [PIXEL_SIZE-1:0] result;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [PIXEL_SIZE-1:0] wr_data;

  modport master (
    output rd_en, rd_addr, data, valid, hsync, vsync, wr_en, wr_addr, wr_data,
    input  rd_data, result
  );

  modport slave (
    input  rd_en, rd_addr, data, valid, hsync, vsync, wr_en, wr_addr, wr_data,
    output rd_data, result
  );
endinterface

// File: rtl/frame_streamer.sv
// Frame streamer: reads a width x height frame from a frame buffer in raster
// order, presents each pixel to a pipelined DUT, and writes each DUT result
// back to the same address LATENCY enabled cycles later.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   en             : global enable, low freezes everything
//   start          : frame start request (sampled in IDLE)
//   width, height  : frame dimensions, latched on accepted start
//   busy, done     : frame in progress / one-cycle completion pulse
//   bus (master)   : read port, pixel stream, result input, write-back port
//
// state  | meaning
// IDLE   | waiting for start
// ACTIVE | issuing one frame-buffer read per enabled cycle
// BLANK  | HBLANK idle cycles between rows
// DRAIN  | waiting for the last results to leave the DUT pipeline
// DONE   | one-cycle completion pulse
module frame_streamer #(
  parameter int PIXEL_SIZE = 24,
  parameter int ADDR_W     = 20,
  parameter int DIM_W      = 12,
  parameter int LATENCY    = 4,
  parameter int HBLANK     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             start,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic             busy,
  output logic             done,
  frame_streamer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_BLANK,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [DIM_W-1:0]  DIM_ONE    = DIM_W'(1);
  // Down-counters end at zero, so load one less than the cycles wanted.
  // DRAIN needs LATENCY+1 cycles: one for the read data, LATENCY for the DUT.
  localparam logic [7:0]        DRAIN_LOAD = 8'(LATENCY);
  localparam logic [7:0]        BLANK_LOAD = 8'(HBLANK - 1);

  state_t            state;
  logic [DIM_W-1:0]  w_q;
  logic [DIM_W-1:0]  h_q;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        cnt;

  logic              valid_q;
  logic              hsync_q;
  logic              vsync_q;
  logic [ADDR_W-1:0] pix_addr;
  logic [LATENCY-1:0] sr_valid;
  logic [ADDR_W-1:0] sr_addr [LATENCY];
  logic              valid_out;

  // Linear address counter equals row*width+col, wrapping modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      w_q   <= '0;
      h_q   <= '0;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
      cnt   <= '0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            w_q   <= width;
            h_q   <= height;
            col   <= '0;
            row   <= '0;
            addr  <= '0;
            state <= (width == '0 || height == '0) ? S_DONE : S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          addr <= addr + ADDR_ONE;
          if (col == w_q - DIM_ONE) begin
            col <= '0;
            if (row == h_q - DIM_ONE) begin
              state <= S_DRAIN;
              cnt   <= DRAIN_LOAD;
            end else begin
              row <= row + DIM_ONE;
              if (HBLANK != 0) begin
                state <= S_BLANK;
                cnt   <= BLANK_LOAD;
              end
            end
          end else begin
            col <= col + DIM_ONE;
          end
        end
        S_BLANK: begin
          if (cnt == '0) state <= S_ACTIVE;
          else           cnt   <= cnt - 8'd1;
        end
        S_DRAIN: begin
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - 8'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-data stage (pixel tags) and the write-back delay line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      pix_addr <= '0;
      sr_valid <= '0;
      for (int i = 0; i < LATENCY; i++) sr_addr[i] <= '0;
    end else if (en) begin
      valid_q <= (state == S_ACTIVE);
      if (state == S_ACTIVE) begin
        pix_addr <= addr;
        hsync_q  <= (col == '0);
        vsync_q  <= (col == '0) && (row == '0);
      end
      sr_valid[0] <= valid_q;
      sr_addr[0]  <= pix_addr;
      for (int i = 1; i < LATENCY; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_addr[i]  <= sr_addr[i-1];
      end
    end
  end

  assign busy = (state == S_ACTIVE) || (state == S_BLANK) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  assign valid_out   = en && valid_q;
  assign bus.rd_en   = en && (state == S_ACTIVE);
  assign bus.rd_addr = addr;
  assign bus.valid   = valid_out;
  // Frame-buffer data is passed straight through in the cycle it arrives;
  // outside that cycle (and in reset) the output is parked at zero.
  assign bus.data    = valid_q ? bus.rd_data : '0;
  assign bus.hsync   = valid_out && hsync_q;
  assign bus.vsync   = valid_out && vsync_q;
  assign bus.wr_en   = en && sr_valid[LATENCY-1];
  assign bus.wr_addr = sr_addr[LATENCY-1];
  assign bus.wr_data = sr_valid[LATENCY-1] ? bus.result : '0;

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: two instances (HBLANK 0 and 2) share stimulus;
// each has its own frame-buffer model and identity DUT pipeline.
module tb_frame_streamer;
  localparam int PS  = 24;
  localparam int AW  = 20;
  localparam int DW  = 12;
  localparam int LAT = 4;
  localparam int HB0 = 0;
  localparam int HB1 = 2;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          en      = 1'b1;
  logic          start   = 1'b0;
  logic [DW-1:0] width   = '0;
  logic [DW-1:0] height  = '0;
  logic          busy_s [2];
  logic          done_s [2];

  frame_streamer_if #(.PIXEL_SIZE(PS), .ADDR_W(AW)) bus0 ();
  frame_streamer_if #(.PIXEL_SIZE(PS), .ADDR_W(AW)) bus1 ();

  frame_streamer #(.PIXEL_SIZE(PS), .ADDR_W(AW), .DIM_W(DW), .LATENCY(LAT), .HBLANK(HB0)) u0 (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start), .width(width), .height(height),
    .busy(busy_s[0]), .done(done_s[0]), .bus(bus0.master));

  frame_streamer #(.PIXEL_SIZE(PS), .ADDR_W(AW), .DIM_W(DW), .LATENCY(LAT), .HBLANK(HB1)) u1 (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start), .width(width), .height(height),
    .busy(busy_s[1]), .done(done_s[1]), .bus(bus1.master));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PS-1:0] pix(int k);
    return PS'((k * 40503 + 17) ^ 32'h005A3C00);
  endfunction

  // Frame buffers (one-cycle read) and identity DUTs (LAT enabled cycles).
  logic [PS-1:0] id0 [LAT];
  logic [PS-1:0] id1 [LAT];
  always @(posedge clk) begin
    if (bus0.rd_en) bus0.rd_data <= pix(int'(bus0.rd_addr));
    if (bus1.rd_en) bus1.rd_data <= pix(int'(bus1.rd_addr));
    if (en) begin
      id0[0] <= bus0.data;
      id1[0] <= bus1.data;
      for (int j = 1; j < LAT; j++) begin
        id0[j] <= id0[j-1];
        id1[j] <= id1[j-1];
      end
    end
  end
  assign bus0.result = id0[LAT-1];
  assign bus1.result = id1[LAT-1];

  logic          rd_en_s [2];
  logic          valid_s [2];
  logic          hsync_s [2];
  logic          vsync_s [2];
  logic          wr_en_s [2];
  logic [AW-1:0] rd_addr_s [2];
  logic [AW-1:0] wr_addr_s [2];
  logic [PS-1:0] data_s [2];
  logic [PS-1:0] wr_data_s [2];
  assign rd_en_s[0]   = bus0.rd_en;   assign rd_en_s[1]   = bus1.rd_en;
  assign valid_s[0]   = bus0.valid;   assign valid_s[1]   = bus1.valid;
  assign hsync_s[0]   = bus0.hsync;   assign hsync_s[1]   = bus1.hsync;
  assign vsync_s[0]   = bus0.vsync;   assign vsync_s[1]   = bus1.vsync;
  assign wr_en_s[0]   = bus0.wr_en;   assign wr_en_s[1]   = bus1.wr_en;
  assign rd_addr_s[0] = bus0.rd_addr; assign rd_addr_s[1] = bus1.rd_addr;
  assign wr_addr_s[0] = bus0.wr_addr; assign wr_addr_s[1] = bus1.wr_addr;
  assign data_s[0]    = bus0.data;    assign data_s[1]    = bus1.data;
  assign wr_data_s[0] = bus0.wr_data; assign wr_data_s[1] = bus1.wr_data;

  // Model: a frame is a timeline in enabled cycles since the accepted start.
  // Pixel k (row r) is read at cycle 1+k+r*HBLANK, presented one cycle later,
  // written back LAT cycles after that; done follows the last write.
  bit m_act [2];
  int m_e   [2];
  int m_w   [2];
  int m_h   [2];
  int m_de  [2];

  function automatic int hb(int i);
    return (i == 0) ? HB0 : HB1;
  endfunction

  function automatic int done_at(int w, int h, int hbv);
    if (w == 0 || h == 0) return 1;
    return w * h + (h - 1) * hbv + LAT + 2;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0;
        m_e[i]   <= 0;
      end
    end else if (en) begin
      for (int i = 0; i < 2; i++) begin
        if (m_act[i]) begin
          if (m_e[i] == m_de[i]) m_act[i] <= 1'b0;
          else                   m_e[i]   <= m_e[i] + 1;
        end else if (start) begin
          m_act[i] <= 1'b1;
          m_e[i]   <= 1;
          m_w[i]   <= int'(width);
          m_h[i]   <= int'(height);
          m_de[i]  <= done_at(int'(width), int'(height), hb(i));
        end
      end
    end
  end

  int  n_chk  = 0;
  int  n_pass = 0;
  int  t_start = 0;
  int  done_lat  [2];
  int  done_cnt  [2];
  int  wr_cnt    [2];
  int  rd_cnt    [2];
  int  hs_cnt    [2];
  int  vs_cnt    [2];
  bit  busy_seen [2];

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_counters();
    for (int i = 0; i < 2; i++) begin
      done_lat[i] = -1; done_cnt[i] = 0; wr_cnt[i] = 0; rd_cnt[i] = 0;
      hs_cnt[i] = 0; vs_cnt[i] = 0; busy_seen[i] = 1'b0;
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      bit e_busy, e_done, e_rd, e_val, e_wr, e_hs, e_vs;
      int k_rd, k_val, k_wr, w, h, er;
      e_busy = 0; e_done = 0; e_rd = 0; e_val = 0; e_wr = 0; e_hs = 0; e_vs = 0;
      k_rd = 0; k_val = 0; k_wr = 0; w = 0; h = 0;
      if (m_act[i]) begin
        w = m_w[i];
        h = m_h[i];
        e_done = (m_e[i] == m_de[i]);
        if (w * h != 0) begin
          e_busy = (m_e[i] < m_de[i]);
          for (int k = 0; k < w * h; k++) begin
            er = 1 + k + (k / w) * hb(i);
            if (er == m_e[i])           begin e_rd  = 1; k_rd  = k; end
            if (er + 1 == m_e[i])       begin e_val = 1; k_val = k; end
            if (er + 1 + LAT == m_e[i]) begin e_wr  = 1; k_wr  = k; end
          end
        end
        if (!en) begin e_rd = 0; e_val = 0; e_wr = 0; end
        if (e_val) begin
          e_hs = ((k_val % w) == 0);
          e_vs = (k_val == 0);
        end
      end
      chk($sformatf("u%0d.busy", i),  busy_s[i],  e_busy);
      chk($sformatf("u%0d.done", i),  done_s[i],  e_done);
      chk($sformatf("u%0d.rd_en", i), rd_en_s[i], e_rd);
      chk($sformatf("u%0d.valid", i), valid_s[i], e_val);
      chk($sformatf("u%0d.hsync", i), hsync_s[i], e_hs);
      chk($sformatf("u%0d.vsync", i), vsync_s[i], e_vs);
      chk($sformatf("u%0d.wr_en", i), wr_en_s[i], e_wr);
      if (e_rd)  chk($sformatf("u%0d.rd_addr", i), rd_addr_s[i], k_rd);
      if (e_val) chk($sformatf("u%0d.data", i),    data_s[i],    pix(k_val));
      if (e_wr) begin
        chk($sformatf("u%0d.wr_addr", i), wr_addr_s[i], k_wr);
        chk($sformatf("u%0d.wr_data", i), wr_data_s[i], pix(k_wr));
      end
      if (!reset_n) begin
        chk($sformatf("u%0d.rst_rd_addr", i), rd_addr_s[i], 0);
        chk($sformatf("u%0d.rst_wr_addr", i), wr_addr_s[i], 0);
        chk($sformatf("u%0d.rst_data", i),    data_s[i],    0);
        chk($sformatf("u%0d.rst_wr_data", i), wr_data_s[i], 0);
      end
      if (done_s[i]) begin
        if (done_lat[i] < 0) done_lat[i] = cyc - t_start;
        done_cnt[i]++;
      end
      if (wr_en_s[i]) wr_cnt[i]++;
      if (rd_en_s[i]) rd_cnt[i]++;
      if (hsync_s[i]) hs_cnt[i]++;
      if (vsync_s[i]) vs_cnt[i]++;
      if (busy_s[i])  busy_seen[i] = 1'b1;
    end
  endtask

  // Called at a falling edge: inputs already set, compare, move to next one.
  task automatic tick();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic kick(int w, int h);
    width  = DW'(w);
    height = DW'(h);
    start  = 1'b1;
    clear_counters();
    t_start = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic frame_lits(string tag, int lat0, int lat1, int n);
    chk({tag, ".u0.done_latency"}, done_lat[0], lat0);
    chk({tag, ".u1.done_latency"}, done_lat[1], lat1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.u%0d.writes", tag, i), wr_cnt[i], n);
      chk($sformatf("%s.u%0d.reads", tag, i),  rd_cnt[i], n);
      chk($sformatf("%s.u%0d.done_pulses", tag, i), done_cnt[i], 1);
    end
  endtask

  initial begin
    clear_counters();
    @(negedge clk);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // 4x2 frame, continuous enable
    kick(4, 2);
    repeat (26) tick();
    frame_lits("t1", 14, 16, 8);
    chk("t1.u0.hsyncs", hs_cnt[0], 2);
    chk("t1.u1.hsyncs", hs_cnt[1], 2);
    chk("t1.u0.vsyncs", vs_cnt[0], 1);

    // 4x2 frame with en low for 3 cycles mid-row, then start/width noise while busy
    kick(4, 2);
    tick();
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    tick();
    width = DW'(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (26) tick();
    frame_lits("t2", 17, 19, 8);

    // 3x3 frame
    kick(3, 3);
    repeat (26) tick();
    frame_lits("t3", 15, 19, 9);
    chk("t3.u1.hsyncs", hs_cnt[1], 3);

    // zero-sized frames
    kick(0, 5);
    repeat (6) tick();
    frame_lits("t4", 1, 1, 0);
    chk("t4.u0.busy_seen", busy_seen[0], 0);
    chk("t4.u1.busy_seen", busy_seen[1], 0);
    kick(3, 0);
    repeat (6) tick();
    frame_lits("t4h", 1, 1, 0);

    // reset at pixel 5 of 8
    kick(4, 2);
    repeat (5) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (26) tick();
    chk("t5.u0.reads_before_reset", rd_cnt[0], 5);
    chk("t5.u0.done_pulses", done_cnt[0], 0);
    chk("t5.u1.done_pulses", done_cnt[1], 0);
    chk("t5.u0.writes", wr_cnt[0], 0);
    chk("t5.u1.busy_after", busy_s[1], 0);

    // fresh start after the aborted frame replays from address 0
    kick(4, 2);
    repeat (26) tick();
    frame_lits("t6", 14, 16, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
